// File: rtl/muldiv_defs.sv
// Shared constants for the multiply/divide sequencer: op codes, FSM state
// encoding, step-mode selects and the default operand width.
package muldiv_defs;

  localparam int WIDTH_DEF = 32;

  // Operation codes presented on the op port
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Iteration mode for the step datapath
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath.
//  MUL: accumulator = {carry, upper[WIDTH], lower[WIDTH]}, multiplier sits in
//       the lower half and is consumed LSB first; multiplicand is added into
//       the upper half, then the whole thing shifts right.
//  DIV: accumulator[2*WIDTH-1:0] = {rem, quo}; restoring shift-subtract with
//       the divisor as operand. Bit 2*WIDTH is unused in this mode.
module muldiv_step
  import muldiv_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               mode,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH:0]   upper_sum;
  logic [2*WIDTH:0] mul_acc;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH:0] div_acc;

  // Compute both step flavours and select by mode
  always_comb begin
    // Shift-add: the carry bit is always clear on entry because the previous
    // step shifted a zero into it, so the WIDTH+1-bit sum cannot overflow.
    upper_sum = acc[2*WIDTH:WIDTH];
    if (acc[0]) begin
      upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, operand};
    end
    mul_acc = {upper_sum, acc[WIDTH-1:0]} >> 1;

    // Shift-subtract: remainder shifted left picks up the next dividend bit.
    // rem < divisor keeps the difference within WIDTH+1 signed bits.
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    trial     = rem_shift - {1'b0, operand};
    div_acc   = '0;
    div_acc[WIDTH-1:0] = {acc[WIDTH-2:0], ~trial[WIDTH]};
    if (trial[WIDTH]) begin
      div_acc[2*WIDTH-1:WIDTH] = rem_shift[WIDTH-1:0];
    end else begin
      div_acc[2*WIDTH-1:WIDTH] = trial[WIDTH-1:0];
    end

    acc_next = (mode == MODE_DIV) ? div_acc : mul_acc;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO.
// Operands are converted to magnitudes on entry, the step datapath runs
// WIDTH iterations, and a final FIX cycle restores signs before HI/LO are
// written, so partial results never appear on hi/lo.
module muldiv_seq
  import muldiv_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH:0]   acc_reg;
  logic [WIDTH-1:0]   operand_reg;
  logic               mode_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;

  logic               is_arith;
  logic               is_div;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH:0]   acc_next;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Decode the request and form operand magnitudes
  always_comb begin
    is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_abs     = a_neg ? (~a + 1'b1) : a;
    b_abs     = b_neg ? (~b + 1'b1) : b;
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode     (mode_reg),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (acc_next)
  );

  // Sign correction applied in the FIX cycle
  always_comb begin
    prod_fixed = neg_q_reg ? (~acc_reg[2*WIDTH-1:0] + 1'b1) : acc_reg[2*WIDTH-1:0];
    quo_fixed  = neg_q_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
    rem_fixed  = neg_r_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];
    if (mode_reg == MODE_DIV) begin
      fix_hi = rem_fixed;
      fix_lo = quo_fixed;
    end else begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end
  end

  // Sequencer FSM, iteration counter and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      acc_reg     <= '0;
      operand_reg <= '0;
      mode_reg    <= MODE_MUL;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (is_arith) begin
              // Multiplier (mul) or dividend (div) starts in the low half
              acc_reg     <= {{(WIDTH+1){1'b0}}, (is_div ? a_abs : b_abs)};
              operand_reg <= is_div ? b_abs : a_abs;
              mode_reg    <= is_div ? MODE_DIV : MODE_MUL;
              // A zero divisor keeps the all-ones quotient un-negated so
              // signed and unsigned divide-by-zero give the same LO.
              neg_q_reg   <= (a_neg ^ b_neg) & ~(is_div & (b == '0));
              neg_r_reg   <= is_div & a_neg;
              count_reg   <= CW'(WIDTH - 1);
              state_reg   <= ST_CALC;
            end else if (op == OP_MTHI) begin
              hi_reg <= a;
            end else if (op == OP_MTLO) begin
              lo_reg <= a;
            end
          end
        end
        ST_CALC: begin
          acc_reg <= acc_next;
          if (count_reg == '0) begin
            state_reg <= ST_FIX;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        ST_FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
